// File: rtl/logic_slice_seq.sv
// logic_slice_seq: multi-cycle bitwise logic unit (AND/OR/XOR/NOR).
// Operands and opcode are latched on an accepted start. The result is built
// one SLICE-bit slice per clock, LSB slice first. Output/zero update only on
// the completion edge, which is also when the one-cycle done pulse begins.
module logic_slice_seq #(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   output logic [WIDTH-1:0] Output,
   output logic             zero,
   output logic             done,
   output logic             busy
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Bitwise operation on one slice; slices are independent (no carries).
   function automatic logic [SLICE-1:0] slice_op(
      input logic [1:0]       f,
      input logic [SLICE-1:0] a,
      input logic [SLICE-1:0] b
   );
      logic [SLICE-1:0] r;
      case (f)
         2'b00:   r = a & b;
         2'b01:   r = a | b;
         2'b10:   r = a ^ b;
         2'b11:   r = ~(a | b);
         default: r = {SLICE{1'b0}};
      endcase
      return r;
   endfunction

   state_t           state_r;
   state_t           state_s;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] scratch_r;
   logic [WIDTH-1:0] out_r;
   logic             zero_r;
   logic [WIDTH-1:0] merged_s;
   logic [SLICE-1:0] slice_s;
   logic             accept_s;
   logic             last_s;

   // Evaluate the current slice and form the full result with it merged in.
   always_comb begin
      slice_s  = slice_op(op_r, a_r[cnt_r*SLICE +: SLICE], b_r[cnt_r*SLICE +: SLICE]);
      merged_s = scratch_r;
      merged_s[cnt_r*SLICE +: SLICE] = slice_s;
      last_s   = (cnt_r == LAST_CNT);
   end

   // Next-state decode; start is honoured only in IDLE or DONE.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s  = ST_RUN;
               accept_s = 1'b1;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_s  = ST_RUN;
               accept_s = 1'b1;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         default: begin
            state_s  = ST_IDLE;
            accept_s = 1'b0;
         end
      endcase
   end

   // State, operand capture, slice accumulation and result publication.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CW{1'b0}};
         a_r       <= {WIDTH{1'b0}};
         b_r       <= {WIDTH{1'b0}};
         op_r      <= 2'b00;
         scratch_r <= {WIDTH{1'b0}};
         out_r     <= {WIDTH{1'b0}};
         zero_r    <= 1'b1;
      end else begin
         state_r <= state_s;
         if (accept_s) begin
            a_r   <= input1;
            b_r   <= input2;
            op_r  <= op;
            cnt_r <= {CW{1'b0}};
         end else if (state_r == ST_RUN) begin
            scratch_r <= merged_s;
            cnt_r     <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (last_s) begin
               out_r  <= merged_s;
               zero_r <= (merged_s == {WIDTH{1'b0}});
            end
         end
      end
   end

   assign Output = out_r;
   assign zero   = zero_r;
   assign done   = (state_r == ST_DONE);
   assign busy   = (state_r == ST_RUN);

endmodule

// File: tb/tb_logic_slice_seq.sv
// Self-checking bench for logic_slice_seq: three instances cover
// (32,4) N=8, (8,8) N=1 and (64,16) N=4.
module tb_logic_slice_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  start_v;
   logic [1:0]  op;
   logic [63:0] in_a;
   logic [63:0] in_b;

   logic [31:0] out0;
   logic        zero0, done0, busy0;
   logic [7:0]  out1;
   logic        zero1, done1, busy1;
   logic [63:0] out2;
   logic        zero2, done2, busy2;

   int          sel;
   logic [63:0] cur_out;
   logic        cur_zero, cur_done, cur_busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   logic_slice_seq #(.WIDTH(32), .SLICE(4)) dut0 (
      .clk(clk), .reset_n(reset_n), .start(start_v[0]), .op(op),
      .input1(in_a[31:0]), .input2(in_b[31:0]),
      .Output(out0), .zero(zero0), .done(done0), .busy(busy0));

   logic_slice_seq #(.WIDTH(8), .SLICE(8)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start_v[1]), .op(op),
      .input1(in_a[7:0]), .input2(in_b[7:0]),
      .Output(out1), .zero(zero1), .done(done1), .busy(busy1));

   logic_slice_seq #(.WIDTH(64), .SLICE(16)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(start_v[2]), .op(op),
      .input1(in_a), .input2(in_b),
      .Output(out2), .zero(zero2), .done(done2), .busy(busy2));

   // Route the selected instance's outputs to common observation signals.
   always_comb begin
      cur_out  = {32'h0000_0000, out0};
      cur_zero = zero0;
      cur_done = done0;
      cur_busy = busy0;
      case (sel)
         1: begin
            cur_out  = {56'h0, out1};
            cur_zero = zero1;
            cur_done = done1;
            cur_busy = busy1;
         end
         2: begin
            cur_out  = out2;
            cur_zero = zero2;
            cur_done = done2;
            cur_busy = busy2;
         end
         default: begin
            cur_out  = {32'h0000_0000, out0};
            cur_zero = zero0;
            cur_done = done0;
            cur_busy = busy0;
         end
      endcase
   end

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", nm, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] a,
                                         input logic [63:0] b, input int s);
      logic [63:0] r;
      case (o)
         2'b00:   r = a & b;
         2'b01:   r = a | b;
         2'b10:   r = a ^ b;
         default: r = ~(a | b);
      endcase
      if (s == 0) r = r & 64'h0000_0000_FFFF_FFFF;
      else if (s == 1) r = r & 64'h0000_0000_0000_00FF;
      return r;
   endfunction

   function automatic int slices_of(input int s);
      if (s == 0) return 8;
      else if (s == 1) return 1;
      else return 4;
   endfunction

   // One accepted operation on instance s: latency, hold of old result while
   // busy, result, zero flag and single-cycle done pulse.
   task automatic run_op(input int s, input logic [1:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input string nm);
      logic [63:0] prev;
      int          cycles;
      int          hold_err;
      @(negedge clk);
      sel  = s;
      op   = o;
      in_a = a;
      in_b = b;
      start_v[s] = 1'b1;
      #1 prev = cur_out;
      @(negedge clk);
      start_v[s] = 1'b0;
      cycles   = 0;
      hold_err = 0;
      while (cur_done !== 1'b1 && cycles < 40) begin
         if (cur_busy !== 1'b1 || cur_out !== prev) hold_err++;
         @(negedge clk);
         cycles++;
      end
      check({nm, " latency"}, 64'(cycles), 64'(slices_of(s)));
      check({nm, " hold"}, 64'(hold_err), 64'd0);
      check({nm, " result"}, cur_out, exp);
      check({nm, " zero"}, {63'd0, cur_zero}, {63'd0, (exp == 64'd0)});
      check({nm, " busy_off"}, {63'd0, cur_busy}, 64'd0);
      @(negedge clk);
      check({nm, " done_pulse"}, {63'd0, cur_done}, 64'd0);
   endtask

   initial begin
      logic [63:0] ra, rb, o1, o2;
      int dn, n1, n2;

      vecs[0] = '{2'b11, 32'h0F0F_0000, 32'h00FF_00F0, 32'hF000_FF0F};
      vecs[1] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[2] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[3] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[4] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[5] = '{2'b00, 32'hA5A5_5A5A, 32'h0FF0_F00F, 32'h05A0_500A};
      vecs[6] = '{2'b10, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678};
      vecs[7] = '{2'b00, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000};

      sel     = 0;
      reset_n = 1'b0;
      start_v = 3'b111;
      op      = 2'b11;
      in_a    = 64'hFFFF_FFFF_FFFF_FFFF;
      in_b    = 64'h0;

      // Reset held two edges with start asserted.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst out", cur_out, 64'd0);
      check("rst zero", {63'd0, cur_zero}, 64'd1);
      check("rst done", {63'd0, cur_done}, 64'd0);
      check("rst busy", {63'd0, cur_busy}, 64'd0);
      start_v = 3'b000;
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle busy", {63'd0, cur_busy}, 64'd0);
      check("idle done", {63'd0, cur_done}, 64'd0);

      // Directed table on the 32/4 instance.
      for (int i = 0; i < 8; i++) begin
         run_op(0, vecs[i].op, {32'h0, vecs[i].a}, {32'h0, vecs[i].b},
                {32'h0, vecs[i].exp}, $sformatf("vec%0d", i));
      end

      // Operand changes and a start pulse mid-RUN must not disturb the result.
      @(negedge clk);
      sel = 0; in_a = 64'h1234_5678; in_b = 64'h0; op = 2'b01; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (2) @(negedge clk);
      in_a = 64'h0; op = 2'b00; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      dn = 0; o1 = 64'h0;
      for (int n = 0; n < 15; n++) begin
         if (cur_done === 1'b1) begin
            dn++;
            o1 = cur_out;
         end
         @(negedge clk);
      end
      check("stab pulses", 64'(dn), 64'd1);
      check("stab result", o1, 64'h1234_5678);

      // Back-to-back: start held high across DONE.
      @(negedge clk);
      op = 2'b00; in_a = 64'hFF00_FF00; in_b = 64'h0F0F_0F0F; start_v[0] = 1'b1;
      @(negedge clk);
      op = 2'b10;
      dn = 0; n1 = 0; n2 = 0; o1 = 64'h0; o2 = 64'h0;
      for (int n = 0; n < 30; n++) begin
         if (cur_done === 1'b1) begin
            if (dn == 0) begin
               n1 = n; o1 = cur_out;
            end else begin
               n2 = n; o2 = cur_out;
            end
            dn++;
         end
         if (dn == 1 && n == n1 + 1) start_v[0] = 1'b0;
         @(negedge clk);
      end
      start_v[0] = 1'b0;
      check("b2b pulses", 64'(dn), 64'd2);
      check("b2b spacing", 64'(n2 - n1), 64'd9);
      check("b2b first", o1, 64'h0F00_0F00);
      check("b2b second", o2, 64'hF00F_F00F);

      // Abort during RUN after slice 5.
      @(negedge clk);
      op = 2'b11; in_a = 64'h0F0F_0000; in_b = 64'h00FF_00F0; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (5) @(negedge clk);
      check("abort busy_pre", {63'd0, cur_busy}, 64'd1);
      reset_n = 1'b0;
      @(negedge clk);
      check("abort out", cur_out, 64'd0);
      check("abort zero", {63'd0, cur_zero}, 64'd1);
      check("abort busy", {63'd0, cur_busy}, 64'd0);
      check("abort done", {63'd0, cur_done}, 64'd0);
      reset_n = 1'b1;
      dn = 0;
      for (int n = 0; n < 12; n++) begin
         if (cur_done === 1'b1) dn++;
         @(negedge clk);
      end
      check("abort no_done", 64'(dn), 64'd0);

      // Parameter sweep: N=1 and N=4.
      run_op(1, 2'b11, 64'h0F, 64'h30, 64'hC0, "w8 nor");
      run_op(1, 2'b00, 64'hF3, 64'h3C, 64'h30, "w8 and");
      run_op(2, 2'b11, 64'h0F0F_0000_1234_0000, 64'h00FF_00F0_0000_8001,
             64'hF000_FF0F_EDCB_7FFE, "w64 nor");
      for (int k = 0; k < 4; k++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         run_op(2, 2'(k), ra, rb, model(2'(k), ra, rb, 2), $sformatf("w64 rnd%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/logic_slice_seq.md
# logic_slice_seq

Parametrised, multi-cycle bitwise logic unit for the datapath's ALU group. It latches two WIDTH-bit operands and an operation code on a start strobe, then evaluates AND/OR/XOR/NOR one SLICE-bit slice per clock, LSB slice first. It publishes the full result with a one-cycle done pulse and a zero flag. It generalises the fixed 32-bit NOR built from 4-bit slices: width and slice size are configurable, the operation is selectable, and evaluation is sequenced with a handshake rather than being purely combinational.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits evaluated per cycle; N = WIDTH/SLICE slice steps (N ≥ 1).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- start  in  1  request strobe; accepted only in IDLE or DONE.
- op  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
- input1  in  WIDTH  operand A.
- input2  in  WIDTH  operand B.
- Output  out  WIDTH  registered result; holds the last completed result.
- zero  out  1  registered; 1 when Output == 0.
- done  out  1  one-cycle pulse; Output/zero valid and updated.
- busy  out  1  high while slices are being evaluated (RUN).

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start=1 → latch input1, input2, op into internal registers; cnt←0; go RUN. start=0 → stay.
- RUN: each edge, the scratch result slice[cnt] ← f(op_q, A_q slice, B_q slice); cnt←cnt+1. Slice k covers bits [k*SLICE+SLICE-1 : k*SLICE].
- On the edge evaluating slice N-1: Output ← complete result (final slice merged in); zero ← (complete result == 0); go DONE.
- DONE: done=1 for exactly this cycle. start=1 → latch new operands/op, cnt←0, go RUN (back-to-back accepted). start=0 → go IDLE.
- start while in RUN is ignored and not queued. Changes on input1/input2/op after acceptance have no effect on the running operation.
- Output and zero change only on the completion edge. They never show partial results and hold their values through IDLE and subsequent RUN phases.
- cnt is ceil(log2(N))-bit wide (minimum 1). N=1 (SLICE=WIDTH) is legal: RUN lasts one cycle.
- NOR/XOR operate bitwise over the full slice; no carry or inter-slice dependency.
- Reset values: Output=0, zero=1, done=0, busy=0, state IDLE, cnt=0, operand/scratch registers 0.
- reset_n=0 during RUN or DONE aborts the operation. Outputs take their reset values on that edge, and the partial result is discarded.
- reset_n=0 has priority over start on the same edge.

## Timing
- busy = (state == RUN), decoded from the state register, with no combinational path from inputs.
- Latency: start sampled at edge E0 → busy high from E0 to EN. Output/zero/done update at EN, where EN is N edges after E0. done is high for the cycle between EN and EN+1.
- Throughput with start held high: one result per N+1 cycles.
- For WIDTH=32, SLICE=4: N=8, so done is high 8 cycles after the accept edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset: hold reset_n=0 for 2 edges with start=1 → Output=0, zero=1, done=0, busy=0. Release → stays IDLE until the next start.
- NOR (32/4): input1=0x0F0F_0000, input2=0x00FF_00F0, op=11, start 1 cycle → busy for 8 cycles, then done pulse with Output=0xF000_FF0F, zero=0. Output must stay at the old value until the done edge.
- All ops and zero flag: A=0xFFFF_FFFF, B=0xFFFF_FFFF → AND=0xFFFF_FFFF (zero=0), OR=0xFFFF_FFFF, XOR=0x0000_0000 (zero=1), NOR=0x0000_0000 (zero=1).
- Operand stability and ignored start: A=0x1234_5678, B=0x0, op=01, accepted. Mid-RUN, change A to 0x0, op to 00, and pulse start → result is still 0x1234_5678, with exactly one done pulse.
- Back-to-back: hold start=1 with two operand sets across the DONE cycle → second operation accepted in DONE; done pulses 9 cycles apart; each result matches its own operands.
- Abort and parameter sweep: assert reset_n=0 at slice 5 → Output=0, zero=1, no done. Repeat the NOR case for (WIDTH,SLICE) = (8,8), N=1, done 1 cycle after accept, and (64,16), N=4, with random operands checked against a bitwise model.
